// File: rtl/multimode_register.sv
// -----------------------------------------------------------------------------
// multimode_register
//
// General-purpose storage / counter / shift element. A single register of
// nrOfBits bits runs one of eight operations on every enabled clock edge:
// hold, parallel load, shift left, shift right, rotate left, modulo count up,
// modulo count down and synchronous clear.
//
// Parameters
//   nrOfBits    register width (1..32)
//   invertClock 0 = update on rising edge of s_clock, 1 = on falling edge
//   maxValue    counter terminal value (<= 2^nrOfBits-1)
//   resetValue  value taken by q on reset and on CLEAR (<= maxValue)
//
// Ports
//   s_clock      in   register clock, active edge chosen by invertClock
//   reset        in   asynchronous, active-high reset (q = resetValue, carry = 0)
//   clockEnable  in   update enable
//   tick         in   global tick; update only when clockEnable & tick
//   mode         in   [2:0] operation select
//   d            in   [nrOfBits-1:0] parallel load data
//   serialIn     in   bit shifted in by SHL / SHR
//   q            out  [nrOfBits-1:0] register contents
//   carry        out  registered carry / terminal / shift-out flag
//   zero         out  combinational, high when q == 0
// -----------------------------------------------------------------------------
module multimode_register #(
  parameter int          nrOfBits    = 8,
  parameter int          invertClock = 0,
  parameter int unsigned maxValue    = 255,
  parameter int unsigned resetValue  = 0
) (
  input  logic                s_clock,
  input  logic                reset,
  input  logic                clockEnable,
  input  logic                tick,
  input  logic [2:0]          mode,
  input  logic [nrOfBits-1:0] d,
  input  logic                serialIn,
  output logic [nrOfBits-1:0] q,
  output logic                carry,
  output logic                zero
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_UP    = 3'b101,
    MODE_DOWN  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  localparam logic [nrOfBits-1:0] max_q   = nrOfBits'(maxValue);
  localparam logic [nrOfBits-1:0] reset_q = nrOfBits'(resetValue);
  localparam logic [nrOfBits-1:0] one_q   = nrOfBits'(1);

  logic [nrOfBits-1:0] q_next;
  logic                carry_next;
  logic                update_en;
  logic [nrOfBits-1:0] serial_lsb;
  logic [nrOfBits-1:0] serial_msb;
  logic [nrOfBits-1:0] msb_lsb;

  assign update_en = clockEnable & tick;
  assign zero      = (q == '0);

  // Shift/rotate are built from whole-word shifts so that nrOfBits = 1
  // degenerates correctly: SHL/SHR give serialIn, ROL gives q unchanged.
  assign serial_lsb = nrOfBits'(serialIn);
  assign serial_msb = nrOfBits'(serialIn) << (nrOfBits - 1);
  assign msb_lsb    = nrOfBits'(q[nrOfBits-1]);

  // NOTE: every output of this block gets a default first so that no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next     = q;
    carry_next = 1'b0;
    case (mode_e'(mode))
      MODE_HOLD: ;
      MODE_LOAD: q_next = d;
      MODE_SHL: begin
        q_next     = (q << 1) | serial_lsb;
        carry_next = q[nrOfBits-1];
      end
      MODE_SHR: begin
        q_next     = (q >> 1) | serial_msb;
        carry_next = q[0];
      end
      MODE_ROL: begin
        q_next     = (q << 1) | msb_lsb;
        carry_next = q[nrOfBits-1];
      end
      MODE_UP: begin
        // q above maxValue (reachable by LOAD) wraps to 0 like the terminal value.
        if (q >= max_q) begin
          q_next     = '0;
          carry_next = 1'b1;
        end else begin
          q_next = q + one_q;
        end
      end
      MODE_DOWN: begin
        if (q == '0) begin
          q_next     = max_q;
          carry_next = 1'b1;
        end else begin
          q_next = q - one_q;
        end
      end
      MODE_CLEAR: q_next = reset_q;
      default: ;
    endcase
  end

  // Only one of the two branches is elaborated, so q and carry have a single
  // driver whichever clock edge is selected.
  if (invertClock != 0) begin : g_fall_edge
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(negedge s_clock or posedge reset) begin
      if (reset) begin
        q     <= reset_q;
        carry <= 1'b0;
      end else if (update_en) begin
        q     <= q_next;
        carry <= carry_next;
      end
    end
  end else begin : g_rise_edge
    always_ff @(posedge s_clock or posedge reset) begin
      if (reset) begin
        q     <= reset_q;
        carry <= 1'b0;
      end else if (update_en) begin
        q     <= q_next;
        carry <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_multimode_register.sv
// -----------------------------------------------------------------------------
// tb_multimode_register
//
// Directed bench for multimode_register. Three instances:
//   u_main : 8 bits, rising edge, maxValue 9, resetValue 0 (table-driven)
//   u_inv  : 8 bits, falling edge, maxValue 255, resetValue 5
//   u_one  : 1 bit,  rising edge, maxValue 1, resetValue 0
// Inputs change 1 time unit after a clock edge; outputs are sampled 1 time
// unit after the edge that should (or should not) have updated them.
// -----------------------------------------------------------------------------
module tb_multimode_register;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_LOAD  = 3'd1;
  localparam logic [2:0] M_SHL   = 3'd2;
  localparam logic [2:0] M_SHR   = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_UP    = 3'd5;
  localparam logic [2:0] M_DOWN  = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic s_clock;

  // u_main signals
  logic       rst_m, ce_m, tk_m, si_m;
  logic [2:0] md_m;
  logic [7:0] d_m, q_m;
  logic       c_m, z_m;

  // u_inv signals
  logic       rst_i, ce_i, tk_i, si_i;
  logic [2:0] md_i;
  logic [7:0] d_i, q_i;
  logic       c_i, z_i;

  // u_one signals
  logic       rst_1, ce_1, tk_1, si_1;
  logic [2:0] md_1;
  logic [0:0] d_1, q_1;
  logic       c_1, z_1;

  int n_cmp  = 0;
  int n_fail = 0;

  multimode_register #(
    .nrOfBits(8), .invertClock(0), .maxValue(9), .resetValue(0)
  ) u_main (
    .s_clock(s_clock), .reset(rst_m), .clockEnable(ce_m), .tick(tk_m),
    .mode(md_m), .d(d_m), .serialIn(si_m), .q(q_m), .carry(c_m), .zero(z_m)
  );

  multimode_register #(
    .nrOfBits(8), .invertClock(1), .maxValue(255), .resetValue(5)
  ) u_inv (
    .s_clock(s_clock), .reset(rst_i), .clockEnable(ce_i), .tick(tk_i),
    .mode(md_i), .d(d_i), .serialIn(si_i), .q(q_i), .carry(c_i), .zero(z_i)
  );

  multimode_register #(
    .nrOfBits(1), .invertClock(0), .maxValue(1), .resetValue(0)
  ) u_one (
    .s_clock(s_clock), .reset(rst_1), .clockEnable(ce_1), .tick(tk_1),
    .mode(md_1), .d(d_1), .serialIn(si_1), .q(q_1), .carry(c_1), .zero(z_1)
  );

  initial s_clock = 1'b0;
  always #5 s_clock = ~s_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] md;
    logic [7:0] d;
    logic       si;
    logic       ce;
    logic       tk;
    logic [7:0] eq;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [2:0] md, input logic [7:0] d,
                     input logic si, input logic ce, input logic tk,
                     input logic [7:0] eq, input logic ec, input logic ez);
    vec_t v;
    v.name = name; v.md = md; v.d = d; v.si = si; v.ce = ce; v.tk = tk;
    v.eq = eq; v.ec = ec; v.ez = ez;
    vecs.push_back(v);
  endtask

  // One enabled/disabled step on the rising-edge instances.
  task automatic step_main(input logic [2:0] md, input logic [7:0] d, input logic si,
                           input logic ce, input logic tk);
    md_m = md; d_m = d; si_m = si; ce_m = ce; tk_m = tk;
    @(posedge s_clock); #1;
  endtask

  task automatic step_one(input logic [2:0] md, input logic si);
    md_1 = md; si_1 = si; ce_1 = 1'b1; tk_1 = 1'b1;
    @(posedge s_clock); #1;
  endtask

  initial begin
    // All instances in reset, idle inputs.
    rst_m = 1'b1; ce_m = 1'b0; tk_m = 1'b0; md_m = M_HOLD; d_m = '0; si_m = 1'b0;
    rst_i = 1'b1; ce_i = 1'b0; tk_i = 1'b0; md_i = M_HOLD; d_i = '0; si_i = 1'b0;
    rst_1 = 1'b1; ce_1 = 1'b0; tk_1 = 1'b0; md_1 = M_HOLD; d_1 = '0; si_1 = 1'b0;
    #1;
    check("rst_main_q", 32'(q_m), 32'h00);
    check("rst_main_carry", 32'(c_m), 32'd0);
    check("rst_main_zero", 32'(z_m), 32'd1);
    check("rst_inv_q", 32'(q_i), 32'h05);
    check("rst_inv_zero", 32'(z_i), 32'd0);
    check("rst_one_q", 32'(q_1), 32'd0);

    @(posedge s_clock); #1;
    rst_m = 1'b0; rst_i = 1'b0; rst_1 = 1'b0;

    // ---------------- table-driven sequence on u_main (maxValue 9) ----------
    //   name               mode     d      si  ce  tk  q      c  z
    add("load_tick0",       M_LOAD,  8'hA5, 0,  1,  0,  8'h00, 0, 1);
    add("load_ce0",         M_LOAD,  8'hA5, 0,  0,  1,  8'h00, 0, 1);
    add("load_a5",          M_LOAD,  8'hA5, 0,  1,  1,  8'hA5, 0, 0);
    add("shl_si1",          M_SHL,   8'h00, 1,  1,  1,  8'h4B, 1, 0);
    add("shr_disabled",     M_SHR,   8'h00, 0,  0,  1,  8'h4B, 1, 0);
    add("shr_si0",          M_SHR,   8'h00, 0,  1,  1,  8'h25, 1, 0);
    add("rol",              M_ROL,   8'h00, 0,  1,  1,  8'h4A, 0, 0);
    add("rol_msb1",         M_ROL,   8'h00, 0,  1,  1,  8'h94, 0, 0);
    add("rol_carry",        M_ROL,   8'h00, 0,  1,  1,  8'h29, 1, 0);
    add("load_8",           M_LOAD,  8'h08, 0,  1,  1,  8'h08, 0, 0);
    add("up_to_9",          M_UP,    8'h00, 0,  1,  1,  8'h09, 0, 0);
    add("up_wrap",          M_UP,    8'h00, 0,  1,  1,  8'h00, 1, 1);
    add("hold_clr_carry",   M_HOLD,  8'h00, 0,  1,  1,  8'h00, 0, 1);
    add("load_1",           M_LOAD,  8'h01, 0,  1,  1,  8'h01, 0, 0);
    add("down_to_0",        M_DOWN,  8'h00, 0,  1,  1,  8'h00, 0, 1);
    add("down_wrap",        M_DOWN,  8'h00, 0,  1,  1,  8'h09, 1, 0);
    add("load_over_max",    M_LOAD,  8'h0C, 0,  1,  1,  8'h0C, 0, 0);
    add("up_over_max",      M_UP,    8'h00, 0,  1,  1,  8'h00, 1, 1);
    add("load_over_max2",   M_LOAD,  8'h0C, 0,  1,  1,  8'h0C, 0, 0);
    add("down_over_max",    M_DOWN,  8'h00, 0,  1,  1,  8'h0B, 0, 0);
    add("clear",            M_CLEAR, 8'h00, 0,  1,  1,  8'h00, 0, 1);
    add("load_37",          M_LOAD,  8'h37, 0,  1,  1,  8'h37, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step_main(vecs[i].md, vecs[i].d, vecs[i].si, vecs[i].ce, vecs[i].tk);
      check({vecs[i].name, "_q"}, 32'(q_m), 32'(vecs[i].eq));
      check({vecs[i].name, "_carry"}, 32'(c_m), 32'(vecs[i].ec));
      check({vecs[i].name, "_zero"}, 32'(z_m), 32'(vecs[i].ez));
    end

    // ---------------- asynchronous reset mid-count on u_main ----------------
    md_m = M_UP; ce_m = 1'b1; tk_m = 1'b1;
    rst_m = 1'b1;
    #1;
    check("async_rst_q", 32'(q_m), 32'h00);
    check("async_rst_carry", 32'(c_m), 32'd0);
    check("async_rst_zero", 32'(z_m), 32'd1);
    @(posedge s_clock); #1;
    check("rst_held_edge_q", 32'(q_m), 32'h00);
    rst_m = 1'b0;
    step_main(M_UP, 8'h00, 1'b0, 1'b0, 1'b1);
    check("post_rst_no_en_q", 32'(q_m), 32'h00);

    // Reset must also clear a pending carry pulse without a clock edge.
    step_main(M_LOAD, 8'h09, 1'b0, 1'b1, 1'b1);
    step_main(M_UP, 8'h00, 1'b0, 1'b1, 1'b1);
    check("pre_rst_carry", 32'(c_m), 32'd1);
    ce_m = 1'b0;
    rst_m = 1'b1;
    #1;
    check("rst_kills_carry", 32'(c_m), 32'd0);
    rst_m = 1'b0;

    // ---------------- falling-edge instance u_inv ---------------------------
    @(negedge s_clock); #1;
    md_i = M_LOAD; d_i = 8'h3C; ce_i = 1'b1; tk_i = 1'b1;
    @(posedge s_clock); #1;
    check("inv_rise_no_update", 32'(q_i), 32'h05);
    @(negedge s_clock); #1;
    check("inv_fall_load", 32'(q_i), 32'h3C);
    md_i = M_CLEAR;
    @(negedge s_clock); #1;
    check("inv_clear_q", 32'(q_i), 32'h05);
    check("inv_clear_carry", 32'(c_i), 32'd0);
    md_i = M_LOAD; d_i = 8'hFF;
    @(negedge s_clock); #1;
    md_i = M_UP;
    @(posedge s_clock); #1;
    check("inv_up_rise_hold", 32'(q_i), 32'hFF);
    @(negedge s_clock); #1;
    check("inv_up_wrap_q", 32'(q_i), 32'h00);
    check("inv_up_wrap_carry", 32'(c_i), 32'd1);
    check("inv_up_wrap_zero", 32'(z_i), 32'd1);
    ce_i = 1'b0;

    // ---------------- 1-bit instance u_one ----------------------------------
    @(posedge s_clock); #1;
    step_one(M_SHL, 1'b1);
    check("one_shl_q", 32'(q_1), 32'd1);
    check("one_shl_carry", 32'(c_1), 32'd0);
    step_one(M_ROL, 1'b0);
    check("one_rol_q", 32'(q_1), 32'd1);
    check("one_rol_carry", 32'(c_1), 32'd1);
    step_one(M_SHR, 1'b0);
    check("one_shr_q", 32'(q_1), 32'd0);
    check("one_shr_carry", 32'(c_1), 32'd1);
    step_one(M_UP, 1'b0);
    check("one_up_q", 32'(q_1), 32'd1);
    check("one_up_carry", 32'(c_1), 32'd0);
    step_one(M_UP, 1'b0);
    check("one_up_wrap_q", 32'(q_1), 32'd0);
    check("one_up_wrap_carry", 32'(c_1), 32'd1);
    step_one(M_DOWN, 1'b0);
    check("one_down_wrap_q", 32'(q_1), 32'd1);
    check("one_down_wrap_carry", 32'(c_1), 32'd1);
    ce_1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multimode_register.md
Name: multimode_register

Overview:
- Parametrised successor to the single-function register flip-flop. One register supports eight modes: hold, parallel load, shift left/right, rotate, modulo count up/down, and synchronous clear.
- Updates are gated by a clock-enable and a global tick, and the active clock edge is selectable.
- Sits in the memory library as the general storage, counter and shift element for generated circuits.

Parameters:
- nrOfBits, 8, register width; legal range 1..32.
- invertClock, 0, 0 = update on rising edge of s_clock; 1 = update on falling edge.
- maxValue, 255, counter terminal value; must be <= 2^nrOfBits-1.
- resetValue, 0, value loaded into q by asynchronous reset and by mode CLEAR; must be <= maxValue.

Ports:
- s_clock  input  1  register clock; active edge selected by invertClock.
- reset  input  1  asynchronous, active-high reset.
- clockEnable  input  1  update enable.
- tick  input  1  global tick; an update occurs only when clockEnable & tick = 1 at the active edge.
- mode  input  3  operation select, see Behaviour.
- d  input  nrOfBits  parallel load data.
- serialIn  input  1  bit shifted in by the SHL and SHR modes.
- q  output  nrOfBits  register contents.
- carry  output  1  registered carry/terminal/shift-out flag.
- zero  output  1  combinational, high when q == 0.

Behaviour:
- Reset (reset=1, asynchronous, active-high): q = resetValue and carry = 0 immediately, with no clock edge required. Reset dominates all other inputs.
- On reset deassertion, the first update happens on the next enabled active edge.
- Enabled edge = active edge of s_clock with clockEnable & tick = 1. On a non-enabled edge, q and carry both hold.
- Mode table, evaluated on each enabled edge:
  - 000 HOLD: q holds; carry <= 0.
  - 001 LOAD: q <= d; carry <= 0.
  - 010 SHL: q <= {q[n-2:0], serialIn}; carry <= q[n-1].
  - 011 SHR: q <= {serialIn, q[n-1:1]}; carry <= q[0].
  - 100 ROL: q <= {q[n-2:0], q[n-1]}; carry <= q[n-1].
  - 101 UP: if q == maxValue then q <= 0 and carry <= 1; otherwise q <= q+1 and carry <= 0.
  - 110 DOWN: if q == 0 then q <= maxValue and carry <= 1; otherwise q <= q-1 and carry <= 0.
  - 111 CLEAR: q <= resetValue; carry <= 0.
- Width rules:
  - nrOfBits = 1: SHL and SHR give q <= serialIn; ROL leaves q unchanged, with carry <= q.
  - All counter arithmetic is modulo maxValue+1 and never exceeds nrOfBits.
  - If q > maxValue (possible after LOAD): UP wraps to 0 with carry=1. DOWN decrements normally.
- Latency: q and carry change one active edge after the inputs are sampled. zero follows q combinationally, with no extra delay.
- Carry is a one-update pulse: it stays valid until the next enabled edge or reset.
- Mode changes take effect on the next enabled edge. No internal state other than q and carry.

Test Plan:
- Reset: assert reset mid-count with q=0x37 and resetValue=0 -> q=0x00 and carry=0 before any edge; zero=1; after release with no enabled edge, q stays 0.
- Load and gating: LOAD d=0xA5 with tick=0 -> q unchanged. Then tick=1, clockEnable=1 -> q=0xA5, carry=0, zero=0.
- Shift and rotate, starting from q=0xA5:
  - SHL serialIn=1 -> q=0x4B, carry=1.
  - then SHR serialIn=0 -> q=0x25, carry=1.
  - then ROL -> q=0x4A, carry=0.
- Count up, maxValue=9: from q=8, UP x2 -> q=9 (carry=0), then q=0 (carry=1); next HOLD -> carry=0.
- Count down, maxValue=9: from q=1, DOWN x2 -> q=0 (zero=1), then q=9 (carry=1).
- Clock inversion: invertClock=1, LOAD d=0x3C -> q updates on the falling edge only, not the rising edge. Also check that CLEAR with resetValue=0x05 gives q=0x05.
